test_end_monitor: RTL and testbench

Synthesizable, parametrised test-completion monitor for the tinyriscv SoC simulation and FPGA bring-up flows. It watches the core PC for up to `NUM_WATCH` programmable "tohost" addresses and counts distinct arrivals at each one. When a channel reaches the hit threshold it samples the result register and reports pass or fail; if no channel finishes within the timeout, it reports a timeout. It sits beside `tinyriscv_soc_top` and is driven by taps on `u_pc_reg.pc_o` and `u_regs.regs[3]`, so both Verilator and board-level checking use the same end-of-test logic.

---
 rtl/test_end_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_test_end_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_end_monitor.sv
// test_end_monitor: watches the core PC for arrivals at programmable
// "tohost" addresses and reports pass, fail or timeout at the end of a test.
module test_end_monitor #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          NUM_WATCH     = 2,
  parameter int          HIT_THRESHOLD = 8,
  parameter int          CNT_WIDTH     = 32,
  parameter int          TIMEOUT_BIT   = 20,
  parameter int          TIMEOUT_EN    = 1,
  parameter logic [31:0] PASS_VALUE    = 32'd1,
  localparam int         EC_W          = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en_i,
  input  logic [ADDR_WIDTH-1:0]           pc_i,
  input  logic [NUM_WATCH*ADDR_WIDTH-1:0] watch_addr_i,
  input  logic [NUM_WATCH-1:0]            watch_en_i,
  input  logic [31:0]                     result_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            pass_o,
  output logic                            fail_o,
  output logic                            timeout_o,
  output logic [EC_W-1:0]                 end_chan_o,
  output logic [31:0]                     fail_code_o,
  output logic [CNT_WIDTH-1:0]            cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]            first_hit_cycle_o,
  output logic [NUM_WATCH*8-1:0]          hit_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A channel completes when its count is one below the threshold and it hits again.
  localparam logic [7:0]           THR_M1  = 8'(HIT_THRESHOLD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state_r, state_s;
  logic [ADDR_WIDTH-1:0]     last_pc_r;
  logic [CNT_WIDTH-1:0]      cycle_cnt_r, cycle_cnt_s;
  logic [CNT_WIDTH-1:0]      first_hit_cycle_r, first_hit_cycle_s;
  logic                      first_seen_r, first_seen_s;
  logic [NUM_WATCH*8-1:0]    hit_cnt_r, hit_cnt_s;
  logic                      pass_r, pass_s;
  logic                      fail_r, fail_s;
  logic                      timeout_r, timeout_s;
  logic [EC_W-1:0]           end_chan_r, end_chan_s;
  logic [31:0]               fail_code_r, fail_code_s;
  logic                      busy_r, done_r;
  logic [NUM_WATCH-1:0]      hit_vec_s;
  logic                      done_hit_s;
  logic [EC_W-1:0]           done_chan_s;

  // Per-channel hit detection: a fresh arrival at an enabled watch address while running.
  always_comb begin
    hit_vec_s = '0;
    for (int k = 0; k < NUM_WATCH; k++) begin
      if ((state_r == ST_RUN) && watch_en_i[k] &&
          (pc_i == watch_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]) && (pc_i != last_pc_r)) begin
        hit_vec_s[k] = 1'b1;
      end else begin
        hit_vec_s[k] = 1'b0;
      end
    end
  end

  // Next-state and next-value logic for the whole monitor.
  always_comb begin
    state_s           = state_r;
    cycle_cnt_s       = cycle_cnt_r;
    hit_cnt_s         = hit_cnt_r;
    first_hit_cycle_s = first_hit_cycle_r;
    first_seen_s      = first_seen_r;
    pass_s            = pass_r;
    fail_s            = fail_r;
    timeout_s         = timeout_r;
    end_chan_s        = end_chan_r;
    fail_code_s       = fail_code_r;
    done_hit_s        = 1'b0;
    done_chan_s       = '0;
    case (state_r)
      ST_IDLE: begin
        if (en_i) begin
          state_s           = ST_RUN;
          cycle_cnt_s       = '0;
          hit_cnt_s         = '0;
          first_hit_cycle_s = '0;
          first_seen_s      = 1'b0;
          pass_s            = 1'b0;
          fail_s            = 1'b0;
          timeout_s         = 1'b0;
          end_chan_s        = '0;
          fail_code_s       = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_s = ST_IDLE;
        end else begin
          cycle_cnt_s = cycle_cnt_r + CNT_ONE;
          for (int k = 0; k < NUM_WATCH; k++) begin
            if (hit_vec_s[k]) begin
              if (hit_cnt_r[k*8 +: 8] != 8'hFF) begin
                hit_cnt_s[k*8 +: 8] = hit_cnt_r[k*8 +: 8] + 8'd1;
              end else begin
                hit_cnt_s[k*8 +: 8] = 8'hFF;
              end
              // Lowest index wins when several channels complete together.
              if ((hit_cnt_r[k*8 +: 8] == THR_M1) && !done_hit_s) begin
                done_hit_s  = 1'b1;
                done_chan_s = EC_W'(k);
              end else begin
                done_hit_s  = done_hit_s;
              end
            end else begin
              hit_cnt_s[k*8 +: 8] = hit_cnt_r[k*8 +: 8];
            end
          end
          if ((|hit_vec_s) && !first_seen_r) begin
            first_seen_s      = 1'b1;
            first_hit_cycle_s = cycle_cnt_r;
          end else begin
            first_seen_s      = first_seen_r;
          end
          // Completion takes priority over a timeout on the same edge.
          if (done_hit_s) begin
            state_s     = ST_DONE;
            fail_code_s = result_i;
            pass_s      = (result_i == PASS_VALUE);
            fail_s      = (result_i != PASS_VALUE);
            end_chan_s  = done_chan_s;
          end else if ((TIMEOUT_EN != 0) && cycle_cnt_r[TIMEOUT_BIT]) begin
            state_s   = ST_DONE;
            timeout_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (!en_i) begin
          state_s   = ST_IDLE;
          pass_s    = 1'b0;
          fail_s    = 1'b0;
          timeout_s = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; last_pc follows the PC in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      last_pc_r         <= '0;
      cycle_cnt_r       <= '0;
      hit_cnt_r         <= '0;
      first_hit_cycle_r <= '0;
      first_seen_r      <= 1'b0;
      pass_r            <= 1'b0;
      fail_r            <= 1'b0;
      timeout_r         <= 1'b0;
      end_chan_r        <= '0;
      fail_code_r       <= 32'd0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      state_r           <= state_s;
      last_pc_r         <= pc_i;
      cycle_cnt_r       <= cycle_cnt_s;
      hit_cnt_r         <= hit_cnt_s;
      first_hit_cycle_r <= first_hit_cycle_s;
      first_seen_r      <= first_seen_s;
      pass_r            <= pass_s;
      fail_r            <= fail_s;
      timeout_r         <= timeout_s;
      end_chan_r        <= end_chan_s;
      fail_code_r       <= fail_code_s;
      busy_r            <= (state_s == ST_RUN);
      done_r            <= (state_s == ST_DONE);
    end
  end

  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign pass_o            = pass_r;
  assign fail_o            = fail_r;
  assign timeout_o         = timeout_r;
  assign end_chan_o        = end_chan_r;
  assign fail_code_o       = fail_code_r;
  assign cycle_cnt_o       = cycle_cnt_r;
  assign first_hit_cycle_o = first_hit_cycle_r;
  assign hit_cnt_o         = hit_cnt_r;

endmodule

// File: tb/tb_test_end_monitor.sv
// Testbench for test_end_monitor: directed table, hand-written corner cases
// and random stimulus against a behavioural reference model.
module tb_test_end_monitor;

  localparam int NW  = 2;
  localparam int THR = 3;
  localparam int TB  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [31:0]     pc;
  logic [NW*32-1:0] waddr;
  logic [NW-1:0]   wen;
  logic [31:0]     res;

  logic            busy, done, pass, fail, tmo;
  logic [0:0]      chan;
  logic [31:0]     code, cyc, fhc;
  logic [NW*8-1:0] hits;

  logic            busy_b, done_b, pass_b, fail_b, tmo_b;
  logic [0:0]      chan_b;
  logic [31:0]     code_b, cyc_b, fhc_b;
  logic [NW*8-1:0] hits_b;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_run, m_done, m_pass, m_fail, m_to, m_first;
  int          m_chan;
  logic [31:0] m_code, m_cyc, m_fhc, m_last;
  int          m_hits[NW];

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] res;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
    logic [7:0]  e_hit0;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  test_end_monitor #(.ADDR_WIDTH(32), .NUM_WATCH(NW), .HIT_THRESHOLD(THR), .CNT_WIDTH(32),
                     .TIMEOUT_BIT(TB), .TIMEOUT_EN(1), .PASS_VALUE(32'd1)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pc_i(pc), .watch_addr_i(waddr),
    .watch_en_i(wen), .result_i(res), .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_o(fail), .timeout_o(tmo), .end_chan_o(chan), .fail_code_o(code),
    .cycle_cnt_o(cyc), .first_hit_cycle_o(fhc), .hit_cnt_o(hits));

  test_end_monitor #(.ADDR_WIDTH(32), .NUM_WATCH(NW), .HIT_THRESHOLD(THR), .CNT_WIDTH(32),
                     .TIMEOUT_BIT(TB), .TIMEOUT_EN(0), .PASS_VALUE(32'd1)) dut_nto (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pc_i(pc), .watch_addr_i(waddr),
    .watch_en_i(wen), .result_i(res), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .fail_o(fail_b), .timeout_o(tmo_b), .end_chan_o(chan_b), .fail_code_o(code_b),
    .cycle_cnt_o(cyc_b), .first_hit_cycle_o(fhc_b), .hit_cnt_o(hits_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_first = 0;
    m_chan = 0; m_code = 0; m_cyc = 0; m_fhc = 0; m_last = 0;
    for (int k = 0; k < NW; k++) m_hits[k] = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at that edge.
  task automatic model_update();
    logic [31:0] prev;
    int fire;
    bit timed;
    prev   = m_last;
    m_last = pc;
    if (m_done) begin
      if (!en) begin
        m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
      end
    end else if (m_run) begin
      if (!en) begin
        m_run = 0;
      end else begin
        fire  = -1;
        timed = ((m_cyc / (32'd1 << TB)) % 2) == 1;
        for (int k = 0; k < NW; k++) begin
          if (wen[k] && pc == waddr[k*32 +: 32] && pc != prev) begin
            if (!m_first) begin
              m_first = 1;
              m_fhc   = m_cyc;
            end
            if (m_hits[k] < 255) m_hits[k]++;
            if (m_hits[k] == THR && fire < 0) fire = k;
          end
        end
        m_cyc = m_cyc + 32'd1;
        if (fire >= 0) begin
          m_run = 0; m_done = 1;
          m_pass = (res == 32'd1); m_fail = !m_pass;
          m_chan = fire; m_code = res;
        end else if (timed) begin
          m_run = 0; m_done = 1; m_to = 1;
        end
      end
    end else if (en) begin
      m_run = 1;
      m_cyc = 0; m_fhc = 0; m_first = 0; m_pass = 0; m_fail = 0; m_to = 0;
      m_chan = 0; m_code = 0;
      for (int k = 0; k < NW; k++) m_hits[k] = 0;
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("timeout", tmo, m_to);
    chk("end_chan", chan, 64'(m_chan));
    chk("fail_code", code, m_code);
    chk("cycle_cnt", cyc, m_cyc);
    chk("first_hit", fhc, m_fhc);
    for (int k = 0; k < NW; k++) chk("hit_cnt", hits[k*8 +: 8], 64'(m_hits[k]));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic e, input logic [31:0] p, input logic [31:0] r);
    en = e; pc = p; res = r;
    step();
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h00, 32'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 32'h00, 32'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 32'hA0, 32'd1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[3] = '{1'b1, 32'h04, 32'd1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[4] = '{1'b1, 32'hA0, 32'd1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[5] = '{1'b1, 32'h08, 32'd1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[6] = '{1'b1, 32'hA0, 32'd1, 1'b0, 1'b1, 1'b1, 8'd3};
    tbl[7] = '{1'b1, 32'hA0, 32'd1, 1'b0, 1'b1, 1'b1, 8'd3};

    rst_n = 1'b0; en = 1'b0; pc = 32'h0; res = 32'h0;
    waddr = {32'hFFFF_FFF0, 32'h0000_00A0}; wen = 2'b01;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cycle", cyc, 32'd0);
    check_all();
    rst_n = 1'b1;

    // basic pass (table)
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].pc, tbl[i].res);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_done", done, tbl[i].e_done);
      chk("tbl_pass", pass, tbl[i].e_pass);
      chk("tbl_hit0", hits[7:0], tbl[i].e_hit0);
    end
    chk("basic_first_hit", fhc, 32'd1);
    chk("basic_fail_code", code, 32'd1);
    chk("basic_end_chan", chan, 1'b0);
    chk("basic_cycle", cyc, 32'd6);
    drive(1'b0, 32'h10, 32'd1);
    chk("done_to_idle_pass", pass, 1'b0);

    // timeout
    drive(1'b1, 32'h10, 32'd1);
    for (int i = 0; i < 64; i++) drive(1'b1, 32'h10, 32'd1);
    chk("to_not_yet", done, 1'b0);
    chk("to_cycle64", cyc, 32'd64);
    drive(1'b1, 32'h10, 32'd1);
    chk("to_fired", tmo, 1'b1);
    chk("to_done", done, 1'b1);
    chk("to_cycle65", cyc, 32'd65);
    chk("to_no_pass", pass | fail, 1'b0);
    for (int i = 0; i < 135; i++) drive(1'b1, 32'h10, 32'd1);
    chk("to_frozen", cyc, 32'd65);
    chk("nto_done", done_b, 1'b0);
    chk("nto_busy", busy_b, 1'b1);
    chk("nto_cycle", cyc_b, 32'd200);
    drive(1'b0, 32'h10, 32'd1);

    // stationary PC: parked at arm is not counted, held PC counts once, then fail
    drive(1'b1, 32'hA0, 32'd5);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hA0, 32'd5);
    chk("parked_hit0", hits[7:0], 8'd0);
    drive(1'b0, 32'hA0, 32'd5);
    drive(1'b1, 32'h00, 32'd5);
    for (int i = 0; i < 10; i++) drive(1'b1, 32'hA0, 32'd5);
    chk("stationary_hit0", hits[7:0], 8'd1);
    drive(1'b1, 32'hA4, 32'd5);
    drive(1'b1, 32'hA0, 32'd5);
    drive(1'b1, 32'hA4, 32'd5);
    drive(1'b1, 32'hA0, 32'd5);
    chk("stat_fail", fail, 1'b1);
    chk("stat_pass", pass, 1'b0);
    chk("stat_code", code, 32'd5);
    drive(1'b0, 32'h00, 32'd5);

    // channel priority and enables
    waddr = {32'hA0, 32'hA0}; wen = 2'b11;
    drive(1'b1, 32'h00, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'hA4, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'hA4, 32'd1);
    drive(1'b1, 32'hA0, 32'd1);
    chk("prio_done", done, 1'b1);
    chk("prio_chan0", chan, 1'b0);
    chk("prio_hit1", hits[15:8], 8'd3);
    drive(1'b0, 32'h00, 32'd1);
    wen = 2'b10;
    drive(1'b1, 32'h00, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'hA4, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'hA4, 32'd1);
    drive(1'b1, 32'hA0, 32'd1);
    chk("en_chan1", chan, 1'b1);
    chk("en_hit0", hits[7:0], 8'd0);
    drive(1'b0, 32'h00, 32'd1);

    // completion and timeout on the same edge (E65)
    waddr = {32'hFFFF_FFF0, 32'hA0}; wen = 2'b01;
    drive(1'b1, 32'h10, 32'd1);
    for (int i = 0; i < 60; i++) drive(1'b1, 32'h10, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'h10, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'h10, 32'd1);
    drive(1'b1, 32'hA0, 32'd1);
    chk("sim_pass", pass, 1'b1);
    chk("sim_timeout", tmo, 1'b0);
    chk("sim_cycle", cyc, 32'd65);
    drive(1'b0, 32'h10, 32'd1);

    // abort, re-arm, asynchronous reset
    drive(1'b1, 32'h00, 32'd1);
    drive(1'b1, 32'hA0, 32'd1); drive(1'b1, 32'h04, 32'd1); drive(1'b1, 32'hA0, 32'd1);
    drive(1'b0, 32'h04, 32'd1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hit0", hits[7:0], 8'd2);
    chk("abort_cycle", cyc, 32'd3);
    drive(1'b1, 32'h04, 32'd1);
    chk("rearm_hit0", hits[7:0], 8'd0);
    chk("rearm_cycle", cyc, 32'd0);
    drive(1'b1, 32'hA0, 32'd1);
    drive(1'b1, 32'h08, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hits", hits, 16'd0);
    chk("rst_cycle", cyc, 32'd0);
    chk("rst_first", fhc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ((i % 40) == 0) begin
        waddr = {32'hA0 + 32'($urandom_range(0, 2)) * 32'd4,
                 32'hA0 + 32'($urandom_range(0, 2)) * 32'd4};
        wen = 2'($urandom_range(0, 3));
      end
      drive(($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1,
            32'hA0 + 32'($urandom_range(0, 3)) * 32'd4,
            ($urandom_range(0, 2) == 0) ? 32'd5 : 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
